shoe_dealer: RTL and testbench
==============================

Name: shoe_dealer

Overview:
- Parametrised successor to the single-deck shuffler: builds and shuffles a shoe of NUM_DECKS x 52 cards, then deals cards one at a time on request.
- Shuffle is an in-place Fisher-Yates driven by a free-running LFSR, with rejection sampling instead of a modulo.
- Adds a deal handshake, blackjack value decode, remaining-card count, cut-card flag, empty-shoe error and reshuffle-on-demand.
- Sits between the game controller and the card/score logic.

Parameters:
- NUM_DECKS, 1: decks in the shoe, 1..8. N = 52*NUM_DECKS.
- IDX_W, 9: index width. Must satisfy 2^IDX_W >= N.
- LFSR_W, 16: LFSR width. Must be >= IDX_W.
- SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- CUT_REMAIN, 26: cut_reached asserts when cards_left <= CUT_REMAIN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- shuffle_start  in  1  one-cycle request to (re)build and shuffle the shoe.
- deal_req  in  1  one-cycle request for the next card.
- ready  out  1  shoe shuffled and dealing permitted.
- card_valid  out  1  one-cycle strobe; card and card_value are valid.
- card  out  6  card id 0..51, equal to suit*13 + rank.
- card_value  out  4  blackjack value 1..10; ace = 1.
- deal_err  out  1  one-cycle pulse: deal_req rejected.
- cards_left  out  IDX_W  undealt cards.
- cut_reached  out  1  cut card passed.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0; state = IDLE; lfsr = SEED; index registers = 0.
  - The deck array is not reset.
- LFSR:
  - Galois, maximal length: x^16+x^14+x^13+x^11+1 for the default width.
  - Advances every clk while rst=1, in every state.
- States: IDLE, INIT, SHUFFLE, READY, EMPTY.
- IDLE: waits for shuffle_start, then goes to INIT.
- INIT:
  - Writes deck[k] = k mod 52 for k = 0..N-1, one entry per cycle (N cycles).
  - Uses a counter-based mod; no divider.
  - Then i = N-1; go to SHUFFLE.
- SHUFFLE:
  - Each cycle: j = lfsr[IDX_W-1:0] & m(i), where m(i) is all ones up to the MSB of i.
  - If j <= i: swap deck[i] and deck[j], then decrement i.
  - If j > i: reject, no change.
  - When i = 0: cards_left = N, dealing pointer p = 0, ready = 1, go to READY.
  - Minimum duration is N-1 cycles; expected duration is at most 2(N-1).
- READY, on deal_req=1:
  - Next cycle: card_valid = 1, card = deck[p], card_value decoded.
  - Same update: p++, cards_left--.
  - If cards_left reaches 0: ready = 0, go to EMPTY.
  - card and card_value hold their values until the next deal; card_valid is high for exactly one cycle.
- card_value decode, with r = card mod 13:
  - r = 0 gives 1.
  - r = 1..8 gives r+1.
  - r = 9..12 gives 10.
- cut_reached: combinational on (state is READY or EMPTY) and cards_left <= CUT_REMAIN.
- EMPTY: deal_req gives a deal_err pulse next cycle; no card_valid.
- deal_req in IDLE, INIT or SHUFFLE: deal_err pulse next cycle; no state change.
- shuffle_start:
  - In READY, EMPTY or IDLE: ready = 0, cards_left = 0, go to INIT.
  - In INIT or SHUFFLE: ignored.
- shuffle_start and deal_req in the same READY cycle: shuffle wins, no card is dealt, deal_err pulses.
- Back-to-back deal_req on consecutive cycles is supported, one card per cycle.
- Reset mid-INIT or mid-SHUFFLE: immediate return to IDLE with outputs 0; a fresh shuffle_start is required.
- Determinism: the same SEED and the same cycle count from reset release to shuffle_start give an identical deal sequence.

Test Plan:
- Reset, NUM_DECKS=1: hold rst=0 for 3 cycles, release -> all outputs 0. deal_req -> deal_err=1 one cycle, card_valid stays 0.
- NUM_DECKS=1: shuffle_start, wait for ready (>= 103 cycles after start), issue 52 deal_req -> 52 card_valid strobes; ids 0..51 each appear exactly once; cards_left falls 52 -> 0; ready drops after the 52nd deal; a 53rd deal_req -> deal_err=1.
- Value decode over a full deal: card 0 -> 1, 8 -> 9, 9 -> 10, 12 -> 10, 13 -> 1, 51 -> 10.
- Cut, NUM_DECKS=1, CUT_REMAIN=26: cut_reached=0 through the 25th deal; it becomes 1 when cards_left=26 after the 26th deal and stays 1 through EMPTY.
- Multi-deck and reshuffle, NUM_DECKS=2: the 104 deals contain every id exactly twice. shuffle_start after 10 deals -> ready=0 at once; a new full shoe of 104 follows.
- Robustness: rst=0 mid-SHUFFLE -> IDLE with outputs 0. Two runs with identical stimulus timing -> identical card sequences. shuffle_start and deal_req together in READY -> deal_err=1, no card_valid, re-shuffle begins.

Source files
------------

// File: rtl/shoe_dealer.sv
// shoe_dealer: builds a shoe of NUM_DECKS x 52 cards, shuffles it in place
// (Fisher-Yates, LFSR-driven, rejection sampling) and deals one card per
// request.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   shuffle_start  one-cycle request to (re)build and shuffle the shoe
//   deal_req       one-cycle request for the next card
//   ready          shoe shuffled, dealing permitted
//   card_valid     one-cycle strobe, card/card_value updated
//   card           card id 0..51 (suit*13 + rank), held until next deal
//   card_value     blackjack value 1..10 (ace = 1), held until next deal
//   deal_err       one-cycle pulse, deal_req rejected
//   cards_left     undealt cards
//   cut_reached    cards_left at or below CUT_REMAIN while dealing
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset, waiting for shuffle_start
// INIT    | writing deck[k] = k mod 52, one entry per cycle
// SHUFFLE | Fisher-Yates from i = N-1 down to 1, rejecting j > i
// READY   | dealing from pointer p
// EMPTY   | shoe exhausted, only a reshuffle leaves this state
module shoe_dealer #(
    parameter int                NUM_DECKS  = 1,
    parameter int                IDX_W      = 9,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                CUT_REMAIN = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shuffle_start,
    input  logic             deal_req,
    output logic             ready,
    output logic             card_valid,
    output logic [5:0]       card,
    output logic [3:0]       card_value,
    output logic             deal_err,
    output logic [IDX_W-1:0] cards_left,
    output logic             cut_reached
);

    localparam int N  = 52 * NUM_DECKS;
    localparam int AW = $clog2(N);
    localparam logic [IDX_W-1:0] N_M1  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] N_CNT = IDX_W'(N);
    // Galois taps for x^16+x^14+x^13+x^11+1; other widths need their own taps.
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(32'h0000_B400);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_READY,
        S_EMPTY
    } state_t;

    state_t state, state_nxt;

    logic [5:0]        deck [N];
    logic [LFSR_W-1:0] lfsr;
    logic [IDX_W-1:0]  k_cnt;
    logic [5:0]        mod_cnt;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  i_mask;
    logic [IDX_W-1:0]  j_idx;
    logic [AW-1:0]     p_idx;
    logic [5:0]        deck_i, deck_j, card_at_p;

    logic start_init, init_wr, swap_en, shuf_done, deal_en, err_en;

    function automatic logic [3:0] bj_value(input logic [5:0] c);
        logic [5:0] r;
        if (c >= 6'd39)      r = c - 6'd39;
        else if (c >= 6'd26) r = c - 6'd26;
        else if (c >= 6'd13) r = c - 6'd13;
        else                 r = c;
        if (r == 6'd0)      return 4'd1;
        else if (r <= 6'd8) return 4'(r + 6'd1);
        else                return 4'd10;
    endfunction

    // Smear i downwards so the mask covers every bit up to i's MSB.
    always_comb begin
        i_mask = i_idx;
        for (int b = 1; b < IDX_W; b++) begin
            i_mask = i_mask | (i_idx >> b);
        end
    end

    assign j_idx     = lfsr[IDX_W-1:0] & i_mask;
    assign deck_i    = deck[i_idx[AW-1:0]];
    assign deck_j    = deck[j_idx[AW-1:0]];
    assign card_at_p = deck[p_idx];

    assign cut_reached = ((state == S_READY) || (state == S_EMPTY)) &&
                         (cards_left <= IDX_W'(CUT_REMAIN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= SEED;
        else      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_init = 1'b0;
        init_wr    = 1'b0;
        swap_en    = 1'b0;
        shuf_done  = 1'b0;
        deal_en    = 1'b0;
        err_en     = 1'b0;
        case (state)
            S_IDLE: begin
                err_en = deal_req;
                if (shuffle_start) begin
                    start_init = 1'b1;
                    state_nxt  = S_INIT;
                end
            end
            S_INIT: begin
                err_en  = deal_req;
                init_wr = 1'b1;
                if (k_cnt == N_M1) state_nxt = S_SHUFFLE;
            end
            S_SHUFFLE: begin
                err_en = deal_req;
                if (j_idx <= i_idx) begin
                    swap_en = 1'b1;
                    // i about to become 0: the last swap completes the shuffle
                    if (i_idx == IDX_W'(1)) begin
                        shuf_done = 1'b1;
                        state_nxt = S_READY;
                    end
                end
            end
            S_READY: begin
                if (shuffle_start) begin
                    // reshuffle wins over a simultaneous deal
                    start_init = 1'b1;
                    err_en     = deal_req;
                    state_nxt  = S_INIT;
                end else if (deal_req) begin
                    deal_en = 1'b1;
                    if (cards_left == IDX_W'(1)) state_nxt = S_EMPTY;
                end
            end
            S_EMPTY: begin
                err_en = deal_req;
                if (shuffle_start) begin
                    start_init = 1'b1;
                    state_nxt  = S_INIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_cnt      <= '0;
            mod_cnt    <= '0;
            i_idx      <= '0;
            p_idx      <= '0;
            cards_left <= '0;
            ready      <= 1'b0;
            card_valid <= 1'b0;
            card       <= '0;
            card_value <= '0;
            deal_err   <= 1'b0;
        end else begin
            card_valid <= deal_en;
            deal_err   <= err_en;
            if (start_init) begin
                k_cnt      <= '0;
                mod_cnt    <= '0;
                ready      <= 1'b0;
                cards_left <= '0;
            end
            if (init_wr) begin
                k_cnt   <= k_cnt + 1'b1;
                mod_cnt <= (mod_cnt == 6'd51) ? 6'd0 : mod_cnt + 6'd1;
                i_idx   <= N_M1;
            end
            if (swap_en) i_idx <= i_idx - 1'b1;
            if (shuf_done) begin
                p_idx      <= '0;
                cards_left <= N_CNT;
                ready      <= 1'b1;
            end
            if (deal_en) begin
                card       <= card_at_p;
                card_value <= bj_value(card_at_p);
                p_idx      <= p_idx + 1'b1;
                cards_left <= cards_left - 1'b1;
                if (cards_left == IDX_W'(1)) ready <= 1'b0;
            end
        end
    end

    // Deck storage carries no reset; INIT rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (init_wr) deck[k_cnt[AW-1:0]] <= mod_cnt;
        if (swap_en) begin
            deck[i_idx[AW-1:0]] <= deck_j;
            deck[j_idx[AW-1:0]] <= deck_i;
        end
    end

endmodule

// File: tb/tb_shoe_dealer.sv
// Testbench for shoe_dealer: one-deck and two-deck instances, a table of
// reset/idle vectors, hand-written corner sequences and randomized traffic
// checked against a behavioural model of the dealing rules.
module tb_shoe_dealer;

    localparam int CUT = 26;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ss  = 1'b0;
    logic dr  = 1'b0;
    int   sel = 0;

    logic       ss1, dr1, ss2, dr2;
    logic       rdy1, val1, err1, cut1, rdy2, val2, err2, cut2;
    logic [5:0] card1, card2;
    logic [3:0] cv1, cv2;
    logic [8:0] left1, left2;

    logic       o_ready, o_valid, o_err, o_cut;
    logic [5:0] o_card;
    logic [3:0] o_cv;
    logic [8:0] o_left;

    assign ss1 = ss & (sel == 0);
    assign dr1 = dr & (sel == 0);
    assign ss2 = ss & (sel == 1);
    assign dr2 = dr & (sel == 1);

    assign o_ready = (sel == 1) ? rdy2  : rdy1;
    assign o_valid = (sel == 1) ? val2  : val1;
    assign o_err   = (sel == 1) ? err2  : err1;
    assign o_cut   = (sel == 1) ? cut2  : cut1;
    assign o_card  = (sel == 1) ? card2 : card1;
    assign o_cv    = (sel == 1) ? cv2   : cv1;
    assign o_left  = (sel == 1) ? left2 : left1;

    shoe_dealer #(.NUM_DECKS(1)) u1 (
        .clk(clk), .rst(rst), .shuffle_start(ss1), .deal_req(dr1),
        .ready(rdy1), .card_valid(val1), .card(card1), .card_value(cv1),
        .deal_err(err1), .cards_left(left1), .cut_reached(cut1)
    );

    shoe_dealer #(.NUM_DECKS(2)) u2 (
        .clk(clk), .rst(rst), .shuffle_start(ss2), .deal_req(dr2),
        .ready(rdy2), .card_valid(val2), .card(card2), .card_value(cv2),
        .deal_err(err2), .cards_left(left2), .cut_reached(cut2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model: 0 idle, 1 busy (init/shuffle), 2 ready, 3 empty
    int mst, mleft, since, nm, last_card;
    int cnt [52];
    int vof [52];
    int seq [$];
    int seq1 [$];
    logic rec = 1'b0;

    typedef struct {
        logic ss;
        logic dr;
        int   ready;
        int   valid;
        int   err;
        int   left;
    } vec_t;
    vec_t tv [7];

    typedef struct {
        int c;
        int v;
    } cv_t;
    cv_t cvt [6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bjv(input int c);
        int r;
        r = c % 13;
        if (r == 0) return 1;
        if (r <= 8) return r + 1;
        return 10;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_err"},   o_err,   0);
        chk({tag, "_left"},  o_left,  0);
        chk({tag, "_cut"},   o_cut,   0);
        chk({tag, "_card"},  o_card,  0);
        chk({tag, "_value"}, o_cv,    0);
    endtask

    task automatic do_reset(input int s);
        @(negedge clk);
        sel = s;
        nm  = (s == 1) ? 104 : 52;
        ss  = 1'b0;
        dr  = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst = 1'b1;
        mst = 0; mleft = 0; since = 0; last_card = 0;
    endtask

    task automatic step(input logic s, input logic d);
        int ev, ee;
        ss = s;
        dr = d;
        @(posedge clk);
        #1;
        ev = 0;
        ee = 0;
        case (mst)
            0: begin
                ee = d;
                if (s) begin mst = 1; since = 0; end
            end
            1: begin
                ee = d;
                since++;
                if (o_ready) begin
                    chk("shuffle_len", int'(since >= 2 * nm - 1), 1);
                    mst = 2;
                    mleft = nm;
                    for (int k = 0; k < 52; k++) cnt[k] = 0;
                end
            end
            2: begin
                if (s) begin
                    ee = d; mst = 1; since = 0; mleft = 0;
                end else if (d) begin
                    ev = 1;
                    mleft--;
                    if (mleft == 0) mst = 3;
                end
            end
            default: begin
                ee = d;
                if (s) begin mst = 1; since = 0; end
            end
        endcase
        chk("valid", o_valid, ev);
        chk("err",   o_err,   ee);
        chk("ready", o_ready, int'(mst == 2));
        chk("left",  o_left,  mleft);
        chk("cut",   o_cut,   int'(mst >= 2 && mleft <= CUT));
        if (ev == 1) begin
            chk("card_range", int'(o_card < 52), 1);
            if (o_card < 52) begin
                chk("value", o_cv, bjv(o_card));
                cnt[o_card]++;
                vof[o_card] = o_cv;
            end
            last_card = o_card;
            if (rec) seq.push_back(int'(o_card));
            if (mst == 3) begin
                for (int k = 0; k < 52; k++) chk("multiset", cnt[k], nm / 52);
            end
        end else begin
            chk("card_hold", o_card, last_card);
        end
    endtask

    task automatic wait_ready();
        int b;
        b = 0;
        while (mst != 2 && b < 3000) begin
            step(1'b0, 1'b0);
            b++;
        end
        chk("ready_timeout", int'(mst == 2), 1);
    endtask

    task automatic deal_n(input int n, input int gaps);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1);
            if (gaps != 0) repeat ($urandom_range(2, 0)) step(1'b0, 1'b0);
        end
    endtask

    task automatic det_run();
        do_reset(0);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        wait_ready();
        seq.delete();
        rec = 1'b1;
        deal_n(52, 0);
        rec = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int mism, ident;

        tv[0] = '{1'b0, 1'b0, 0, 0, 0, 0};
        tv[1] = '{1'b0, 1'b1, 0, 0, 1, 0};
        tv[2] = '{1'b0, 1'b0, 0, 0, 0, 0};
        tv[3] = '{1'b1, 1'b1, 0, 0, 1, 0};
        tv[4] = '{1'b0, 1'b1, 0, 0, 1, 0};
        tv[5] = '{1'b1, 1'b0, 0, 0, 0, 0};
        tv[6] = '{1'b0, 1'b0, 0, 0, 0, 0};

        cvt[0] = '{0, 1};
        cvt[1] = '{8, 9};
        cvt[2] = '{9, 10};
        cvt[3] = '{12, 10};
        cvt[4] = '{13, 1};
        cvt[5] = '{51, 10};

        for (int k = 0; k < 52; k++) vof[k] = -1;

        // single deck: reset/idle vectors, full shoe, over-deal
        do_reset(0);
        for (int t = 0; t < 7; t++) begin
            step(tv[t].ss, tv[t].dr);
            chk("vec_ready", o_ready, tv[t].ready);
            chk("vec_valid", o_valid, tv[t].valid);
            chk("vec_err",   o_err,   tv[t].err);
            chk("vec_left",  o_left,  tv[t].left);
        end
        wait_ready();
        deal_n(52, 1);
        chk("empty_ready", o_ready, 0);
        step(1'b0, 1'b1);
        chk("deal53_err", o_err, 1);
        chk("empty_cut", o_cut, 1);
        for (int t = 0; t < 6; t++) chk("value_table", vof[cvt[t].c], cvt[t].v);

        // determinism and non-trivial shuffle
        det_run();
        seq1 = seq;
        det_run();
        chk("det_len", seq.size(), seq1.size());
        mism = 0;
        ident = 0;
        for (int k = 0; k < seq.size() && k < seq1.size(); k++) begin
            if (seq[k] != seq1[k]) mism++;
            if (seq1[k] == k) ident++;
        end
        chk("det_seq", mism, 0);
        chk("not_identity", int'(ident < 52), 1);

        // reset mid-shuffle, then no resumption without a new start
        do_reset(0);
        step(1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b0);
        chk("mid_shuffle_busy", mst, 1);
        do_reset(0);
        repeat (250) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // shuffle_start together with deal_req while dealing
        step(1'b1, 1'b0);
        wait_ready();
        deal_n(3, 0);
        step(1'b1, 1'b1);
        chk("ss_dr_err", o_err, 1);
        chk("ss_dr_valid", o_valid, 0);
        step(1'b0, 1'b1);
        wait_ready();
        deal_n(52, 0);

        // two decks: full shoe, reshuffle from empty, reshuffle mid-shoe
        do_reset(1);
        step(1'b1, 1'b0);
        wait_ready();
        deal_n(104, 1);
        step(1'b1, 1'b0);
        wait_ready();
        deal_n(10, 0);
        step(1'b1, 1'b0);
        chk("reshuf_ready", o_ready, 0);
        chk("reshuf_left", o_left, 0);
        wait_ready();
        deal_n(104, 1);

        // randomized traffic
        do_reset(0);
        for (int t = 0; t < 2000; t++)
            step(($urandom_range(149, 0) == 0), $urandom_range(1, 0) == 1);
        do_reset(1);
        for (int t = 0; t < 1500; t++)
            step(($urandom_range(149, 0) == 0), $urandom_range(1, 0) == 1);

        ss = 1'b0;
        dr = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
